instruction_encoder: RTL

Converts decoded RISC-V RV32IM instruction fields (format, opcode, register indices, funct3/funct7, sign-extended immediate) back into 32-bit instruction words and streams them, tagged with a sequential word address, toward instruction memory. It is the inverse of the core's decode stage. It is used by the program loader and by self-test generators to build instruction images in hardware. Requests enter through a valid/ready handshake, are legality-checked and encoded, and are buffered in an output FIFO.

---
 rtl/instruction_encoder.sv | 135 +++++++++++++
 1 files changed

// File: rtl/instruction_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instruction_encoder
// Description : Packs decoded RV32IM fields into 32-bit instruction words and
//               queues them, tagged with a running word address, in a FIFO.
//               Optional macro ENC_RANGE_CHECK_EN rejects immediates that do
//               not fit the selected format instead of truncating them.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_encoder #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    input  logic        addr_load,
    input  logic [31:0] addr_value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err,
    output logic [15:0] enc_count
);

    localparam int unsigned c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(FIFO_DEPTH);

    logic [63:0]         r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;
    logic [31:0]         r_addr;
    logic [15:0]         r_enc_count;
    logic                r_err;

    logic        w_accept;
    logic        w_legal;
    logic        w_imm_ok;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_word;
    logic [31:0] w_tag_addr;

    assign in_ready   = !rst && (r_count < c_depth);
    assign w_accept   = in_valid && in_ready;
    assign w_legal    = (in_fmt < 3'd6) && (in_opcode[1:0] == 2'b11) && w_imm_ok;
    assign w_push     = w_accept && w_legal;
    assign w_pop      = out_valid && out_ready;
    // A same-cycle load tags the word being pushed with the new address.
    assign w_tag_addr = addr_load ? (addr_value & 32'hFFFF_FFFC) : r_addr;

    always_comb begin
        w_word = 32'h0;
        case (in_fmt)
            3'd0: w_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            3'd1: w_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            3'd2: w_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            3'd3: w_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], in_opcode};
            3'd4: w_word = {in_imm[31:12], in_rd, in_opcode};
            3'd5: w_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                            in_rd, in_opcode};
            default: w_word = 32'h0;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    // Upper immediate bits must be a pure sign extension of the encoded field.
    always_comb begin
        w_imm_ok = 1'b1;
        case (in_fmt)
            3'd1, 3'd2: w_imm_ok = (&in_imm[31:11]) || !(|in_imm[31:11]);
            3'd3:       w_imm_ok = ((&in_imm[31:12]) || !(|in_imm[31:12])) && !in_imm[0];
            3'd4:       w_imm_ok = (in_imm[11:0] == 12'h000);
            3'd5:       w_imm_ok = ((&in_imm[31:20]) || !(|in_imm[31:20])) && !in_imm[0];
            default:    w_imm_ok = 1'b1;
        endcase
    end
`else
    assign w_imm_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_addr      <= BASE_ADDR;
            r_enc_count <= 16'h0;
            r_err       <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
            r_addr      <= w_push ? (w_tag_addr + 32'd4) : w_tag_addr;
            r_enc_count <= r_enc_count + {15'h0, w_push};
            r_err       <= w_accept && !w_legal;
        end
    end

    // Storage is not reset; the read side is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_word, w_tag_addr};
        end
    end

    assign out_valid = (r_count != '0);
    assign out_instr = out_valid ? r_mem[r_rd_ptr][63:32] : 32'h0;
    assign out_addr  = out_valid ? r_mem[r_rd_ptr][31:0]  : 32'h0;
    assign err       = r_err;
    assign enc_count = r_enc_count;

endmodule
`default_nettype wire
